sigdiv_iter: RTL and testbench

- Iterative radix-2 restoring significand divider for the binary16 datapath. It is the divide-side counterpart of the significand multiplier.
- Takes two normalized significands (hidden bit included) and produces a quotient with NQ bits plus a sticky bit for downstream normalize/round.
- Computes one quotient bit per cycle using a single NSIG+1-bit subtractor.
- Uses valid/ready handshakes on both input and output.

---
 rtl/sigdiv_iter.sv | 91 +++++++++
 tb/tb_sigdiv_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sigdiv_iter.sv
// Iterative radix-2 restoring significand divider for the binary16 datapath.
// Produces NQ quotient bits MSB first, one per cycle, plus a sticky bit.
module sigdiv_iter #(
  parameter  int NSIG = 11,
  parameter  int NQ   = NSIG + 2,
  localparam int CW   = $clog2(NQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NSIG-1:0] a_sig,
  input  logic [NSIG-1:0] b_sig,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NQ-1:0]   q,
  output logic            sticky,
  output logic            dz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [NSIG:0]   rem;
  logic [NSIG-1:0] div;
  logic [CW-1:0]   cnt;

  logic [NSIG+1:0] diff;
  logic            ge;
  logic [NSIG:0]   rem_sel;
  logic [NSIG:0]   rem_next;

  // The remainder stays below 2*div, so the top bit of the wide difference
  // is a reliable sign; a zero divisor always compares as "fits".
  always_comb begin
    diff     = {1'b0, rem} - {2'b00, div};
    ge       = ~diff[NSIG+1] | dz;
    rem_sel  = ge ? diff[NSIG:0] : rem;
    rem_next = rem_sel << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      q         <= '0;
      sticky    <= 1'b0;
      dz        <= 1'b0;
      rem       <= '0;
      div       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            rem      <= {1'b0, a_sig};
            div      <= b_sig;
            q        <= '0;
            sticky   <= 1'b0;
            cnt      <= CW'(NQ - 1);
            dz       <= (b_sig == '0);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          q[cnt] <= ge;
          rem    <= rem_next;
          if (cnt == '0) begin
            sticky    <= (rem_next != '0) && !dz;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigdiv_iter.sv
// Self-checking bench for sigdiv_iter: directed table, random vectors against
// an arithmetic reference, plus stall and mid-run reset sequences.
module tb_sigdiv_iter;

  localparam int NSIG = 11;
  localparam int NQ   = 13;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NSIG-1:0] a_sig;
  logic [NSIG-1:0] b_sig;
  logic            out_valid;
  logic            out_ready;
  logic [NQ-1:0]   q;
  logic            sticky;
  logic            dz;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sigdiv_iter #(.NSIG(NSIG), .NQ(NQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_sig    (a_sig),
    .b_sig    (b_sig),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .sticky   (sticky),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NSIG-1:0] a;
    logic [NSIG-1:0] b;
    logic [NQ-1:0]   q;
    logic            sticky;
    logic            dz;
  } vec_t;

  task automatic check(input string name, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: quotient of a*2^(NQ-1) by b, plain integer arithmetic.
  task automatic ref_div(input logic [NSIG-1:0] a, input logic [NSIG-1:0] b,
                         output logic [NQ-1:0] eq, output logic es, output logic ed);
    longint num;
    num = longint'(a) * (longint'(1) << (NQ - 1));
    if (b == 0) begin
      eq = '1; es = 1'b0; ed = 1'b1;
    end else begin
      eq = NQ'(num / longint'(b));
      es = (num % longint'(b)) != 0;
      ed = 1'b0;
    end
  endtask

  // Issue one divide and wait for the result; result left pending in DONE.
  task automatic start_div(input logic [NSIG-1:0] a, input logic [NSIG-1:0] b,
                           output int lat);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    a_sig = a; b_sig = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [NSIG-1:0] a,
                           input logic [NSIG-1:0] b);
    int lat;
    logic [NQ-1:0] eq;
    logic es, ed;
    ref_div(a, b, eq, es, ed);
    start_div(a, b, lat);
    check({tag, "_latency"}, lat, NQ);
    check({tag, "_q"}, q, eq);
    check({tag, "_sticky"}, sticky, es);
    check({tag, "_dz"}, dz, ed);
    release_result();
  endtask

  vec_t vecs[6];

  initial begin
    logic [NQ-1:0] hq;
    logic hs, hd;
    int lat;

    vecs[0] = '{a: 11'h400, b: 11'h400, q: 13'h1000, sticky: 1'b0, dz: 1'b0};
    vecs[1] = '{a: 11'h7FF, b: 11'h400, q: 13'h1FFC, sticky: 1'b0, dz: 1'b0};
    vecs[2] = '{a: 11'h400, b: 11'h600, q: 13'h0AAA, sticky: 1'b1, dz: 1'b0};
    vecs[3] = '{a: 11'h400, b: 11'h7FF, q: 13'h0801, sticky: 1'b1, dz: 1'b0};
    vecs[4] = '{a: 11'h555, b: 11'h000, q: 13'h1FFF, sticky: 1'b0, dz: 1'b1};
    vecs[5] = '{a: 11'h600, b: 11'h400, q: 13'h1800, sticky: 1'b0, dz: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_sig = '0; b_sig = '0;
    #23;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_sticky", sticky, 0);
    check("rst_dz", dz, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed table; entry 5 after entry 4 also shows dz clearing.
    for (int i = 0; i < 6; i++) begin
      start_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, NQ);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_sticky", i), sticky, vecs[i].sticky);
      check($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
      release_result();
    end

    // Random legal operands, occasional zero divisor.
    for (int i = 0; i < 40; i++) begin
      logic [NSIG-1:0] ra, rb;
      ra = NSIG'($urandom_range(11'h7FF, 11'h400));
      rb = ($urandom_range(9, 0) == 0) ? '0 : NSIG'($urandom_range(11'h7FF, 11'h400));
      run_check($sformatf("rnd%0d", i), ra, rb);
    end

    // Stall in DONE while new operands are offered.
    ref_div(11'h5A5, 11'h4C3, hq, hs, hd);
    start_div(11'h5A5, 11'h4C3, lat);
    check("stall_latency", lat, NQ);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      a_sig = NSIG'($urandom_range(11'h7FF, 11'h400));
      b_sig = NSIG'($urandom_range(11'h7FF, 11'h400));
      @(posedge clk); #1;
      check($sformatf("stall%0d_q", i), q, hq);
      check($sformatf("stall%0d_sticky", i), sticky, hs);
      check($sformatf("stall%0d_in_ready", i), in_ready, 0);
      check($sformatf("stall%0d_out_valid", i), out_valid, 1);
    end
    in_valid = 1'b0;
    release_result();
    check("stall_rel_out_valid", out_valid, 0);
    check("stall_rel_in_ready", in_ready, 1);
    run_check("after_stall", 11'h6B1, 11'h5F0);

    // Reset during RUN with a divide-by-zero in flight.
    a_sig = 11'h555; b_sig = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_q", q, 0);
    check("midrst_dz", dz, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_check("post_midrst", 11'h600, 11'h400);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
